mbisr_repair_mem: RTL and testbench
===================================

MBISR_REPAIR_MEM -- requirements
Module: mbisr_repair_mem

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 4, word address width; DATA_W, default 4, data width; SPARES, default 2, number of spare words.
REQ-002 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  access request from the MBIST engine.
- req_ready  out  1  request accepted when req_valid and req_ready are both high.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse carrying read data.
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid.
- rep_valid  in  1  repair request pulse from the BISR logic.
- rep_addr  in  ADDR_W  faulty address to remap.
- rep_ack  out  1  pulse: repair installed or already present.
- rep_fail  out  1  pulse: no spare left, repair refused.
- rep_used  out  2  number of spares allocated (saturates at SPARES).
- flt_set  in  1  loads the fault-injection register.
- flt_addr  in  ADDR_W  faulty main-array word.
- flt_bit  in  2  faulty bit index.
- flt_sa  in  1  stuck-at value.

Function
REQ-003 The main array SHALL be 2^ADDR_W words of DATA_W flops; the spare array SHALL be SPARES words, each with a tag (addr) and a valid bit.
REQ-004 The FSM SHALL have states IDLE, RCHK, RINS; reset state IDLE.
REQ-005 req_ready SHALL be 1 only in IDLE with rep_valid low; rep_valid in IDLE SHALL have priority over a simultaneous request.
REQ-006 IDLE + rep_valid SHALL capture rep_addr and go to RCHK.
REQ-007 RCHK SHALL: on tag hit, pulse rep_ack and go to IDLE; on miss with a free spare, go to RINS; on miss with all spares full, pulse rep_fail and go to IDLE.
REQ-008 RINS SHALL write the tag into the lowest free spare, set its valid bit, clear its data to 0, increment rep_used, pulse rep_ack, and go to IDLE.
REQ-009 An accepted write SHALL update the spare word if the address hits a valid tag; otherwise it SHALL update the main array.
REQ-010 An accepted read SHALL assert rsp_valid exactly one cycle after acceptance; the read source SHALL be the spare word on a hit, else the main word.
REQ-011 Main-array read data SHALL have bit flt_bit forced to flt_sa when the fault is armed and the address equals flt_addr; spare reads SHALL never be faulted.
REQ-012 flt_set SHALL load the fault register and arm it, taking effect for reads accepted in the following cycle or later; the fault is never disarmed except by reset.
REQ-013 Back-to-back reads SHALL produce back-to-back rsp_valid pulses.
REQ-014 A write followed by a read of the same address SHALL return the new data, with no stall.
REQ-015 rsp_valid, rep_ack, and rep_fail SHALL each be high for exactly one cycle per event.

Reset
REQ-016 Asserting rst_n low SHALL immediately force: FSM to IDLE; rsp_valid, rep_ack, rep_fail to 0; rsp_rdata to 0; rep_used to 0; all spare valid bits, tags, and data to 0; all main words to 0; fault disarmed.
REQ-017 Reset asserted mid-repair SHALL discard the repair with no ack or fail pulse.
REQ-018 A read in flight at reset SHALL produce no rsp_valid pulse.

Structure
REQ-019 A shared package SHALL hold the FSM state enum, the default ADDR_W, DATA_W, and SPARES, and the fault-register struct (addr, bit, sa, armed).
REQ-020 The tag lookup SHALL be one sub-module, mbisr_spare_cam: addr in; hit, hit_idx, free_idx, and full out; purely combinational.

Verification
REQ-021 A bench SHALL cover these directed scenarios (stimulus -> required response):
- Reset, write 0xA to addr 3, read addr 3 -> rsp_rdata 0xA exactly one cycle after acceptance.
- Fault at addr 5, bit 2, stuck-at 0; write 0xF to addr 5; read addr 5 -> 0xB; repair addr 5 -> rep_ack 2 cycles after rep_valid, rep_used 1; write 0xF, read -> 0xF.
- Repair addrs 1, 2, 3 in turn -> ack, ack, rep_fail; rep_used stays 2; repeat repair of addr 1 -> rep_ack, rep_used unchanged.
- rep_valid and req_valid in the same cycle -> req_ready 0; request accepted only after the FSM returns to IDLE.
- Reset asserted while in RINS -> no ack; rep_used 0; a read of the repaired address returns main-array data.
- 8 back-to-back reads -> 8 consecutive rsp_valid pulses, each with correct data.

Source files
------------

// File: rtl/mbisr_repair_mem_pkg.sv
// Shared types for the self-repairing memory: FSM states,
// default geometry and the fault-injection register layout.
package mbisr_repair_mem_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_SPARES = 2;

  // Fault address is held wide so any ADDR_W fits.
  localparam int FLT_AW = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RCHK = 2'd1,
    ST_RINS = 2'd2
  } state_e;

  typedef struct packed {
    logic [FLT_AW-1:0] addr;
    logic [1:0]        bit_idx;
    logic              sa;
    logic              armed;
  } flt_t;

endpackage

// File: rtl/mbisr_spare_cam.sv
// Combinational tag lookup over the spare words.
// addr in; hit/hit_idx, lowest free_idx and full out.
module mbisr_spare_cam
  import mbisr_repair_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int SPARES = DEF_SPARES,
  parameter int IDX_W  = 1
) (
  input  logic [ADDR_W-1:0]             addr,
  input  logic [SPARES-1:0][ADDR_W-1:0] tags,
  input  logic [SPARES-1:0]             valid,
  output logic                          hit,
  output logic [IDX_W-1:0]              hit_idx,
  output logic [IDX_W-1:0]              free_idx,
  output logic                          full
);

  // Descending scan: the last assignment wins, so the
  // lowest-numbered free spare is reported.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    full     = &valid;
    for (int i = SPARES - 1; i >= 0; i--) begin
      if (valid[i] && tags[i] == addr) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!valid[i]) begin
        free_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mbisr_repair_mem.sv
// Memory with spare-word repair and a stuck-at fault injector.
// Ports: req_* access, rsp_* read data, rep_* repair, flt_* fault.
module mbisr_repair_mem
  import mbisr_repair_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SPARES = DEF_SPARES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              rep_valid,
  input  logic [ADDR_W-1:0] rep_addr,
  output logic              rep_ack,
  output logic              rep_fail,
  output logic [1:0]        rep_used,
  input  logic              flt_set,
  input  logic [ADDR_W-1:0] flt_addr,
  input  logic [1:0]        flt_bit,
  input  logic              flt_sa
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int IDX_W = (SPARES > 1) ? $clog2(SPARES) : 1;

  state_e state_q, state_d;
  logic [ADDR_W-1:0] rep_addr_q, rep_addr_d;
  logic [SPARES-1:0][ADDR_W-1:0] tag_q, tag_d;
  logic [SPARES-1:0] sv_q, sv_d;
  logic [SPARES-1:0][DATA_W-1:0] sdat_q, sdat_d;
  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [1:0] used_q, used_d;
  flt_t flt_q, flt_d;
  logic rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic ack_q, ack_d;
  logic fail_q, fail_d;

  logic [ADDR_W-1:0] cam_addr;
  logic cam_hit, cam_full;
  logic [IDX_W-1:0] hit_idx, free_idx;
  logic acc;
  logic [DATA_W-1:0] rd_main;

  // Requests are only taken in IDLE, so the CAM can be
  // shared between the access path and the repair path.
  assign cam_addr = (state_q == ST_IDLE) ? req_addr
                                         : rep_addr_q;

  mbisr_spare_cam #(
    .ADDR_W (ADDR_W),
    .SPARES (SPARES),
    .IDX_W  (IDX_W)
  ) u_cam (
    .addr     (cam_addr),
    .tags     (tag_q),
    .valid    (sv_q),
    .hit      (cam_hit),
    .hit_idx  (hit_idx),
    .free_idx (free_idx),
    .full     (cam_full)
  );

  assign req_ready = (state_q == ST_IDLE) && !rep_valid;
  assign acc       = req_valid && req_ready;

  always_comb begin
    rd_main = mem_q[req_addr];
    if (flt_q.armed && flt_q.addr == FLT_AW'(req_addr)) begin
      rd_main[flt_q.bit_idx] = flt_q.sa;
    end
  end

  always_comb begin
    state_d     = state_q;
    rep_addr_d  = rep_addr_q;
    tag_d       = tag_q;
    sv_d        = sv_q;
    sdat_d      = sdat_q;
    mem_d       = mem_q;
    used_d      = used_q;
    flt_d       = flt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    ack_d       = 1'b0;
    fail_d      = 1'b0;

    if (flt_set) begin
      flt_d.addr    = FLT_AW'(flt_addr);
      flt_d.bit_idx = flt_bit;
      flt_d.sa      = flt_sa;
      flt_d.armed   = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (rep_valid) begin
          rep_addr_d = rep_addr;
          state_d    = ST_RCHK;
        end else if (acc) begin
          if (req_we) begin
            if (cam_hit) sdat_d[hit_idx] = req_wdata;
            else mem_d[req_addr] = req_wdata;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = cam_hit ? sdat_q[hit_idx] : rd_main;
          end
        end
      end
      ST_RCHK: begin
        if (cam_hit) begin
          ack_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (!cam_full) begin
          state_d = ST_RINS;
        end else begin
          fail_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_RINS: begin
        tag_d[free_idx]  = rep_addr_q;
        sv_d[free_idx]   = 1'b1;
        sdat_d[free_idx] = '0;
        used_d           = used_q + 2'd1;
        ack_d            = 1'b1;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rep_addr_q  <= '0;
      tag_q       <= '0;
      sv_q        <= '0;
      sdat_q      <= '0;
      mem_q       <= '0;
      used_q      <= '0;
      flt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      ack_q       <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rep_addr_q  <= rep_addr_d;
      tag_q       <= tag_d;
      sv_q        <= sv_d;
      sdat_q      <= sdat_d;
      mem_q       <= mem_d;
      used_q      <= used_d;
      flt_q       <= flt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      ack_q       <= ack_d;
      fail_q      <= fail_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rep_ack   = ack_q;
  assign rep_fail  = fail_q;
  assign rep_used  = used_q;

endmodule

// File: tb/tb_mbisr_repair_mem.sv
// Directed bench for mbisr_repair_mem: vector table for
// plain accesses plus sequences for repair/fault/reset.
module tb_mbisr_repair_mem;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [3:0] req_addr = '0;
  logic [3:0] req_wdata = '0;
  logic       rsp_valid;
  logic [3:0] rsp_rdata;
  logic       rep_valid = 1'b0;
  logic [3:0] rep_addr = '0;
  logic       rep_ack;
  logic       rep_fail;
  logic [1:0] rep_used;
  logic       flt_set = 1'b0;
  logic [3:0] flt_addr = '0;
  logic [1:0] flt_bit = '0;
  logic       flt_sa = 1'b0;

  int checks = 0;
  int errors = 0;

  mbisr_repair_mem dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rep_valid (rep_valid),
    .rep_addr  (rep_addr),
    .rep_ack   (rep_ack),
    .rep_fail  (rep_fail),
    .rep_used  (rep_used),
    .flt_set   (flt_set),
    .flt_addr  (flt_addr),
    .flt_bit   (flt_bit),
    .flt_sa    (flt_sa)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    rep_valid = 1'b0;
    flt_set   = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  // One access per cycle; the response is checked right
  // after the accepting edge.
  task automatic do_req(input string name, input logic we,
                        input logic [3:0] a,
                        input logic [3:0] d);
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    chk({name, ".ready"}, req_ready, 1);
    step();
    req_valid = 1'b0;
    chk({name, ".rsp_valid"}, rsp_valid, we ? 0 : 1);
    if (!we) chk({name, ".rdata"}, rsp_rdata, d);
  endtask

  // Latency counts edges after the edge that took rep_valid.
  task automatic do_rep(input string name,
                        input logic [3:0] a,
                        input int exp_ack, input int exp_lat);
    int lat = -1;
    int ga = 0;
    int gf = 0;
    int pulses = 0;
    rep_addr  = a;
    rep_valid = 1'b1;
    step();
    rep_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (rep_ack || rep_fail) begin
        pulses++;
        if (lat < 0) begin
          lat = c;
          ga  = rep_ack;
          gf  = rep_fail;
        end
      end
      if (c < 4) step();
    end
    chk({name, ".ack"}, ga, exp_ack);
    chk({name, ".fail"}, gf, exp_ack ? 0 : 1);
    chk({name, ".lat"}, lat, exp_lat);
    chk({name, ".pulses"}, pulses, 1);
  endtask

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [3:0] data;
  } vec_t;

  vec_t vt[17];

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    vt[0]  = '{1'b1, 4'd3, 4'hA};
    vt[1]  = '{1'b0, 4'd3, 4'hA};
    vt[2]  = '{1'b1, 4'd0, 4'h1};
    vt[3]  = '{1'b1, 4'd1, 4'h2};
    vt[4]  = '{1'b1, 4'd2, 4'h4};
    vt[5]  = '{1'b1, 4'd4, 4'h8};
    vt[6]  = '{1'b1, 4'd5, 4'hC};
    vt[7]  = '{1'b1, 4'd6, 4'h5};
    vt[8]  = '{1'b1, 4'd7, 4'hE};
    vt[9]  = '{1'b0, 4'd0, 4'h1};
    vt[10] = '{1'b0, 4'd1, 4'h2};
    vt[11] = '{1'b0, 4'd2, 4'h4};
    vt[12] = '{1'b0, 4'd3, 4'hA};
    vt[13] = '{1'b0, 4'd4, 4'h8};
    vt[14] = '{1'b0, 4'd5, 4'hC};
    vt[15] = '{1'b0, 4'd6, 4'h5};
    vt[16] = '{1'b0, 4'd7, 4'hE};

    #12 rst_n = 1'b1;
    step();
    chk("rst.ready", req_ready, 1);
    chk("rst.rsp_valid", rsp_valid, 0);
    chk("rst.rdata", rsp_rdata, 0);
    chk("rst.used", rep_used, 0);
    chk("rst.ack", rep_ack, 0);
    chk("rst.fail", rep_fail, 0);
    do_req("rst.rd9", 1'b0, 4'd9, 4'h0);

    // Vector table: write then back-to-back reads.
    for (int i = 0; i < 17; i++) begin
      do_req($sformatf("vec%0d", i), vt[i].we,
             vt[i].addr, vt[i].data);
    end
    step();
    chk("vec.rsp_drop", rsp_valid, 0);

    // Fault injection, taking effect one cycle late.
    do_req("flt.wr", 1'b1, 4'd5, 4'hF);
    flt_addr = 4'd5;
    flt_bit  = 2'd2;
    flt_sa   = 1'b0;
    flt_set  = 1'b1;
    do_req("flt.same", 1'b0, 4'd5, 4'hF);
    flt_set = 1'b0;
    do_req("flt.rd", 1'b0, 4'd5, 4'hB);
    do_req("flt.other", 1'b0, 4'd4, 4'h8);
    do_rep("rep5", 4'd5, 1, 2);
    chk("rep5.used", rep_used, 1);
    do_req("rep5.clr", 1'b0, 4'd5, 4'h0);
    do_req("rep5.wr", 1'b1, 4'd5, 4'hF);
    do_req("rep5.rd", 1'b0, 4'd5, 4'hF);

    // Spare exhaustion and repeat repair.
    do_reset();
    do_rep("rep1", 4'd1, 1, 2);
    chk("rep1.used", rep_used, 1);
    do_rep("rep2", 4'd2, 1, 2);
    chk("rep2.used", rep_used, 2);
    do_rep("rep3", 4'd3, 0, 1);
    chk("rep3.used", rep_used, 2);
    do_rep("rep1b", 4'd1, 1, 1);
    chk("rep1b.used", rep_used, 2);
    do_req("sp.wr", 1'b1, 4'd2, 4'h6);
    do_req("sp.rd", 1'b0, 4'd2, 4'h6);

    // Repair has priority over a simultaneous request.
    req_we    = 1'b0;
    req_addr  = 4'd2;
    req_valid = 1'b1;
    rep_addr  = 4'd7;
    rep_valid = 1'b1;
    #1;
    chk("prio.ready0", req_ready, 0);
    step();
    rep_valid = 1'b0;
    n = 1;
    while (!req_ready && n < 10) begin
      chk("prio.norsp", rsp_valid, 0);
      step();
      n++;
    end
    chk("prio.wait", n, 2);
    chk("prio.fail", rep_fail, 1);
    step();
    req_valid = 1'b0;
    chk("prio.rsp_valid", rsp_valid, 1);
    chk("prio.rdata", rsp_rdata, 6);

    // Reset while inserting a spare.
    do_reset();
    rep_addr  = 4'd4;
    rep_valid = 1'b1;
    step();
    rep_valid = 1'b0;
    step();
    chk("rins.preack", rep_ack, 0);
    rst_n = 1'b0;
    #1;
    chk("rins.ack", rep_ack, 0);
    chk("rins.used", rep_used, 0);
    #2 rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (rep_ack || rep_fail) n++;
    end
    chk("rins.nopulse", n, 0);
    chk("rins.used2", rep_used, 0);
    do_req("rins.wr", 1'b1, 4'd4, 4'h8);
    do_req("rins.rd", 1'b0, 4'd4, 4'h8);
    flt_addr = 4'd4;
    flt_bit  = 2'd0;
    flt_sa   = 1'b1;
    flt_set  = 1'b1;
    step();
    flt_set = 1'b0;
    do_req("rins.main", 1'b0, 4'd4, 4'h9);

    // Read response cleared by reset.
    do_req("inf.rd", 1'b0, 4'd4, 4'h9);
    rst_n = 1'b0;
    #1;
    chk("inf.rsp_valid", rsp_valid, 0);
    chk("inf.rdata", rsp_rdata, 0);
    #2 rst_n = 1'b1;
    step();
    chk("inf.after", rsp_valid, 0);
    do_req("inf.unflt", 1'b0, 4'd4, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
